// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, EX-stage training and mispredict redirect
// Optional BP_STATS_EN builds the resolved-branch and mispredict counters; otherwise they read 0.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  ex_hit;
    logic                  ex_update;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[31:INDEX_BITS+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Gating with rst keeps the lookup quiet for the whole reset pulse, not just after the clear lands.
    assign pred_taken  = !rst && if_valid && if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[31:INDEX_BITS+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_update = ex_valid && ex_is_branch;

    always_comb begin
        mispredict = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch)
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            else
                mispredict = ex_pred_taken;
        end
    end

    assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_update) begin
            if (ex_taken) begin
                if (ex_hit) begin
                    if (ctr_q[ex_idx] != 2'b11)
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    target_q[ex_idx] <= ex_target;
                end else begin
                    // Allocation overwrites whatever lived at this index, weakly taken.
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= ex_target;
                    ctr_q[ex_idx]    <= 2'b10;
                end
            end else if (ex_hit && ctr_q[ex_idx] != 2'b00) begin
                ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
            end
        end else if (ex_valid && ex_pred_taken) begin
            // A non-branch predicted taken means the entry aliased; drop it.
            valid_q[ex_idx] <= 1'b0;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (ex_update)
                branches_q <= branches_q + 32'd1;
            if (mispredict)
                mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed checks of branch_predictor against a table model
module tb_branch_predictor;

    localparam int IB = 4;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_br  = 0;
    int unsigned m_mis = 0;

    logic        obs_pred;
    logic        obs_mis;
    logic [31:0] obs_red;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int idx = int'(pc[IB+1:2]);
        return m_valid[idx] && (m_tag[idx] == (pc >> (IB + 2)));
    endfunction

    task automatic check_stats();
`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mis);
`else
        check("stat_branches", stat_branches, 32'd0);
        check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    endtask

    // One fetch/EX cycle: drive, compare combinational outputs, clock, then advance the model.
    task automatic step(input bit iv, input logic [31:0] ipc,
                        input bit ev, input bit eb, input logic [31:0] epc,
                        input bit et, input logic [31:0] etgt,
                        input bit ept, input logic [31:0] eptgt);
        bit          e_pred, e_mis, hit;
        logic [31:0] e_ptgt, e_red;
        int          idx;
        if_valid = iv; if_pc = ipc;
        ex_valid = ev; ex_is_branch = eb; ex_pc = epc; ex_taken = et;
        ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
        #2;
        idx    = int'(ipc[IB+1:2]);
        e_pred = !rst && iv && model_hit(ipc) && (m_ctr[idx] >= 2);
        e_ptgt = e_pred ? m_tgt[idx] : ipc + 32'd4;
        if (!ev)     e_mis = 0;
        else if (eb) e_mis = (et != ept) || (et && etgt != eptgt);
        else         e_mis = ept;
        e_red = (eb && et) ? etgt : epc + 32'd4;
        obs_pred = pred_taken; obs_mis = mispredict; obs_red = redirect_pc;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pred});
        check("pred_target", pred_target, e_ptgt);
        check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        if (e_mis) check("redirect_pc", redirect_pc, e_red);
        check_stats();
        @(posedge clk);
        if (!rst && ev) begin
            idx = int'(epc[IB+1:2]);
            hit = model_hit(epc);
            if (eb) begin
                m_br++;
                if (et) begin
                    if (hit) begin
                        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    end else begin
                        m_valid[idx] = 1;
                        m_tag[idx]   = epc >> (IB + 2);
                        m_ctr[idx]   = 2;
                    end
                    m_tgt[idx] = etgt;
                end else if (hit && m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else if (ept) begin
                m_valid[idx] = 0;
            end
            if (e_mis) m_mis++;
        end
        #1;
    endtask

    task automatic probe(input string tag, input logic [31:0] ipc,
                         input bit e_pred, input logic [31:0] e_tgt);
        if_valid = 1'b1; if_pc = ipc; ex_valid = 1'b0;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, e_pred});
        check({tag, "_target"}, pred_target, e_tgt);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit eb, input bit et,
                           input logic [31:0] tgt, input bit ept, input logic [31:0] eptgt);
        step(1'b0, 32'd0, 1'b1, eb, pc, et, tgt, ept, eptgt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 3))
            0: p = 32'h0000_0000;
            1: p = 32'h0000_0040;
            2: p = 32'h0000_1000;
            default: p = 32'hFFFF_FFC0;
        endcase
        return p | ($urandom_range(0, N - 1) << 2);
    endfunction

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        probe("reset_lookup", 32'h100, 1'b0, 32'h104);
        check_stats();

        // Allocation on a mispredicted taken branch; same-cycle lookup sees the old entry.
        step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        check("alloc_mis", {31'd0, obs_mis}, 32'd1);
        check("alloc_red", obs_red, 32'h40);
        check("alloc_same_cycle", {31'd0, obs_pred}, 32'd0);
        probe("after_alloc", 32'h100, 1'b1, 32'h40);

        resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
        resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
        resolve(32'h100, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
        probe("ctr_10", 32'h100, 1'b1, 32'h40);
        resolve(32'h100, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
        probe("ctr_01", 32'h100, 1'b0, 32'h104);

        resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
        probe("alias_miss", 32'h140, 1'b0, 32'h144);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        check("alias_mis", {31'd0, obs_mis}, 32'd1);
        check("alias_red", obs_red, 32'h104);
        probe("alias_cleared", 32'h100, 1'b0, 32'h104);

        resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
        step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
        check("same_cycle_old", {31'd0, obs_pred}, 32'd1);
        probe("same_cycle_new", 32'h100, 1'b0, 32'h104);

        check("wrap_pc4", 32'hFFFF_FFFC + 32'd4, 32'd0);
        resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        check("wrap_red", obs_red, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] p, t;
            bit pt;
            p  = rand_pc();
            t  = rand_pc();
            pt = $urandom_range(0, 1);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) == 0) ? p : rand_pc(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, p,
                 $urandom_range(0, 1), t, pt,
                 ($urandom_range(0, 1) == 1) ? t : rand_pc());
        end

        // Reset mid-cycle with a trained entry visible.
        resolve(32'h200, 1'b1, 1'b1, 32'h80, 1'b0, 32'h204);
        probe("pre_rst", 32'h200, 1'b1, 32'h80);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h200; ex_taken = 1'b1;
        ex_target = 32'h80; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        rst = 1'b1;
        #1;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h204);
        check("rst_mispredict", {31'd0, mispredict}, 32'd1);
        model_clear();
        step(1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h0);
        rst = 1'b0;
        probe("post_rst", 32'h200, 1'b0, 32'h204);
        check_stats();

        // Five branches, two of them mispredicted.
        resolve(32'h300, 1'b1, 1'b1, 32'h500, 1'b0, 32'h304);
        resolve(32'h300, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
        resolve(32'h300, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
        resolve(32'h304, 1'b1, 1'b0, 32'h0, 1'b0, 32'h308);
        resolve(32'h300, 1'b1, 1'b0, 32'h500, 1'b1, 32'h500);
        ex_valid = 1'b0;
        #1;
`ifdef BP_STATS_EN
        check("five_branches", stat_branches, 32'd5);
        check("two_mispredicts", stat_mispredicts, 32'd2);
`else
        check("five_branches", stat_branches, 32'd0);
        check("two_mispredicts", stat_mispredicts, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor for the RISC-V pipeline: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It predicts direction and target for the PC being fetched. It is trained and checked by the EX-stage branch resolution (the branch unit's taken flag). It raises a mispredict/redirect to the PC logic when the resolved outcome disagrees with the prediction carried down the pipeline.

## Interface
- INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[INDEX_BITS+1:2]
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch PC valid this cycle
- if_pc  in  32  PC being fetched
- pred_taken  out  1  predicted taken (combinational from table)
- pred_target  out  32  predicted next PC
- ex_valid  in  1  instruction in EX is valid (already gated by flush)
- ex_is_branch  in  1  EX instruction is conditional branch, JAL or JALR
- ex_pc  in  32  PC of EX instruction
- ex_taken  in  1  resolved taken flag from the branch unit
- ex_target  in  32  resolved target address
- ex_pred_taken  in  1  prediction made at fetch for this instruction
- ex_pred_target  in  32  predicted target made at fetch
- mispredict  out  1  redirect fetch and flush younger stages (combinational)
- redirect_pc  out  32  correct next PC when mispredict=1
- stat_branches  out  32  resolved branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Entry: valid, tag = pc[31:INDEX_BITS+2], target[31:0], ctr[1:0].
- Reset: all valid=0, ctr=2'b01, target=0. Stat counters=0.
- Lookup: hit = valid[idx] && tag match.
  - pred_taken = if_valid && hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4.
- Update (rising edge, ex_valid && ex_is_branch, index/tag from ex_pc):
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= ex_target.
  - Hit, not taken: ctr saturating −1 (00 stays 00); target unchanged.
  - Miss, taken: allocate (overwrite): valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no write.
- Alias cleanup: ex_valid && !ex_is_branch && ex_pred_taken -> valid[idx] <= 0.
- mispredict = ex_valid && either:
  - ex_is_branch && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)); or
  - !ex_is_branch && ex_pred_taken.
- redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4. It is valid only when mispredict=1.
- All PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 = 0).

## Timing
- Lookup is zero-latency combinational. Update is visible to lookups from the cycle after the edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry.
- mispredict/redirect_pc are combinational in the EX cycle. The PC register captures redirect_pc at the same edge the table updates.
- No backpressure. Every ex_valid cycle is consumed in one cycle.
- Reset asserted mid-operation: the table is invalidated immediately, so pred_taken=0 and pred_target=if_pc+4 while rst=1. Updates and stat increments are suppressed while rst=1. mispredict still follows the ex_* inputs combinationally.

## Configuration
- BP_STATS_EN defined: stat_branches increments on each ex_valid && ex_is_branch edge. stat_mispredicts increments on each edge with mispredict=1. Both are 32-bit and wrap to 0.
- BP_STATS_EN undefined: both ports are present and tied to 0. No counter flops are built.

## Test plan
- Reset, then if_pc=0x100, if_valid=1 -> pred_taken=0, pred_target=0x104.
- EX: ex_pc=0x100, branch, taken, target 0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40. Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x40.
- Train 0x100 taken three times, then not taken once -> ctr goes 10→11→11→10, and 0x100 still predicts taken. A second not-taken -> 01, and it predicts not taken.
- Alias: 0x140 (same index as 0x100 with INDEX_BITS=4, different tag) -> miss, pred_taken=0. Then 0x100 resolves as non-branch with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104, and the entry is invalidated.
- Same-cycle lookup and update on 0x100 -> the lookup shows the old counter, and the new value appears next cycle. Assert rst mid-run -> pred_taken drops to 0 at once.
- BP_STATS_EN: 5 branches with 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Without the macro both read 0.
